unidade_controle: RTL and testbench

Multi-cycle control unit directly upstream of the register-bank/ALU datapath block (BLOCO).
- Accepts 16-bit instruction words over a valid/ready handshake.
- Decodes each word into the datapath controls: Hab_Escrita, Sel_SA, Sel_SB, Sel_SC, controleOperacao, reset_Flags.
- Sequences each instruction through fixed DECODE/EXEC/WRITE cycles, one instruction in flight at a time.

---
 rtl/unidade_controle.sv | 110 +++++++++++
 tb/tb_unidade_controle.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/unidade_controle.sv
// Multi-cycle control unit: accepts instruction words and sequences DECODE/EXEC/WRITE for the BLOCO datapath.
// Optional build macro INSTR_COUNT_EN adds a 16-bit completed-instruction counter output (instr_count).
//
// state  | meaning
// IDLE   | ready for a new word; selects hold their last value
// DECODE | word latched; Sel_SA/Sel_SB/controleOperacao driven
// EXEC   | operands held stable; Sel_SC driven with rd
// WRITE  | Hab_Escrita (ALU op) or reset_Flags (CLRF) pulses for one cycle
module unidade_controle #(
    parameter int bits_palavra  = 16,
    parameter int end_registros = 2,
    parameter int bits_op       = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [bits_palavra-1:0]  instr,
    input  logic                     instr_valid,
    output logic                     instr_ready,
    output logic                     Hab_Escrita,
    output logic [end_registros-1:0] Sel_SA,
    output logic [end_registros-1:0] Sel_SB,
    output logic [end_registros-1:0] Sel_SC,
    output logic [bits_op-1:0]       controleOperacao,
    output logic                     reset_Flags,
    output logic                     busy
`ifdef INSTR_COUNT_EN
    ,
    output logic [15:0]              instr_count
`endif
);

    localparam int RD_MSB = bits_palavra - bits_op - 1;
    localparam int RA_MSB = RD_MSB - end_registros;
    localparam int RB_MSB = RA_MSB - end_registros;

    localparam logic [bits_op-1:0] OP_NOP  = '1;
    localparam logic [bits_op-1:0] OP_CLRF = {{(bits_op-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WRITE} state_t;

    state_t                     state_q, state_d;
    logic [bits_op-1:0]         ir_op;
    logic [end_registros-1:0]   ir_rd;
    logic                       accept;

    // Low instruction bits are don't-care by definition of the encoding.
    logic unused_instr;
    assign unused_instr = &{1'b0, instr};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d     = state_q;
        instr_ready = 1'b0;
        Hab_Escrita = 1'b0;
        reset_Flags = 1'b0;
        accept      = 1'b0;
        case (state_q)
            IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    accept  = 1'b1;
                    state_d = DECODE;
                end
            end
            DECODE: state_d = EXEC;
            EXEC:   state_d = WRITE;
            WRITE: begin
                if (ir_op == OP_CLRF)     reset_Flags = 1'b1;
                else if (ir_op != OP_NOP) Hab_Escrita = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    // Operand selects load together with the instruction register so they are valid throughout DECODE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ir_op            <= '0;
            ir_rd            <= '0;
            Sel_SA           <= '0;
            Sel_SB           <= '0;
            Sel_SC           <= '0;
            controleOperacao <= '0;
        end else begin
            if (accept) begin
                ir_op            <= instr[bits_palavra-1 -: bits_op];
                ir_rd            <= instr[RD_MSB -: end_registros];
                Sel_SA           <= instr[RA_MSB -: end_registros];
                Sel_SB           <= instr[RB_MSB -: end_registros];
                controleOperacao <= instr[bits_palavra-1 -: bits_op];
            end
            if (state_q == DECODE) Sel_SC <= ir_rd;
        end
    end

`ifdef INSTR_COUNT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)               instr_count <= 16'd0;
        else if (state_q == WRITE)  instr_count <= instr_count + 16'd1;
    end
`endif

endmodule

// File: tb/tb_unidade_controle.sv
// Self-checking bench for unidade_controle: randomized instruction words checked against a field-level reference model.
// Counter checks are included when INSTR_COUNT_EN is defined.
module tb_unidade_controle;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [15:0] instr = 16'h0;
    logic        instr_valid = 1'b0;
    logic        instr_ready, Hab_Escrita, reset_Flags, busy;
    logic [1:0]  Sel_SA, Sel_SB, Sel_SC;
    logic [4:0]  controleOperacao;
`ifdef INSTR_COUNT_EN
    logic [15:0] instr_count;
`endif

    unidade_controle dut (
        .clk(clk),
        .reset_n(reset_n),
        .instr(instr),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .Hab_Escrita(Hab_Escrita),
        .Sel_SA(Sel_SA),
        .Sel_SB(Sel_SB),
        .Sel_SC(Sel_SC),
        .controleOperacao(controleOperacao),
        .reset_Flags(reset_Flags),
        .busy(busy)
`ifdef INSTR_COUNT_EN
        ,
        .instr_count(instr_count)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;

    // Reference model: fields by plain arithmetic on the 16-bit word
    function automatic logic [4:0] m_op(input logic [15:0] w); return 5'((w >> 11) % 32); endfunction
    function automatic logic [1:0] m_rd(input logic [15:0] w); return 2'((w >> 9) % 4); endfunction
    function automatic logic [1:0] m_ra(input logic [15:0] w); return 2'((w >> 7) % 4); endfunction
    function automatic logic [1:0] m_rb(input logic [15:0] w); return 2'((w >> 5) % 4); endfunction
    function automatic logic m_write(input logic [15:0] w); return (m_op(w) != 5'd31) && (m_op(w) != 5'd30); endfunction
    function automatic logic m_clrf(input logic [15:0] w);  return m_op(w) == 5'd30; endfunction

    // Monitors
    int          cyc = 0;
    logic [15:0] acc_q[$];
    int          acc_t[$];
    logic [1:0]  hab_sc[$];
    int          hab_t[$];
    int          rf_cnt = 0;
    int          both_hi = 0;

    always @(posedge clk) begin
        if (reset_n && instr_valid && instr_ready) begin
            acc_q.push_back(instr);
            acc_t.push_back(cyc);
        end
        cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (Hab_Escrita) begin
            hab_sc.push_back(Sel_SC);
            hab_t.push_back(cyc);
        end
        if (reset_Flags) rf_cnt++;
        if (Hab_Escrita && reset_Flags) both_hi++;
    end

    // Per-phase observations captured by run_one
    logic [1:0] d_sa, d_sb, e_sa, e_sb, e_sc, w_sc;
    logic [4:0] d_op, e_op;
    logic d_ready, d_busy, d_hab, d_rf, e_busy, e_hab, e_rf, w_busy, w_hab, w_rf, i_ready, i_busy, i_hab, i_rf;

    task automatic run_one(input logic [15:0] w);
        instr = w;
        instr_valid = 1'b1;
        @(negedge clk);
        {d_sa, d_sb, d_op, d_ready, d_busy, d_hab, d_rf} = {Sel_SA, Sel_SB, controleOperacao, instr_ready, busy, Hab_Escrita, reset_Flags};
        instr_valid = 1'b0;
        instr = 16'($urandom);
        @(negedge clk);
        {e_sa, e_sb, e_op, e_sc, e_busy, e_hab, e_rf} = {Sel_SA, Sel_SB, controleOperacao, Sel_SC, busy, Hab_Escrita, reset_Flags};
        @(negedge clk);
        {w_sc, w_busy, w_hab, w_rf} = {Sel_SC, busy, Hab_Escrita, reset_Flags};
        @(negedge clk);
        {i_ready, i_busy, i_hab, i_rf} = {instr_ready, busy, Hab_Escrita, reset_Flags};
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({instr_ready, busy, Hab_Escrita, reset_Flags} !== 4'b1000)
            $display("FAIL reset_ctrl: got %b expected 1000", {instr_ready, busy, Hab_Escrita, reset_Flags});
        else passed++;
        checks++;
        if ({Sel_SA, Sel_SB, Sel_SC, controleOperacao} !== 11'h0)
            $display("FAIL reset_sel: got %h expected 0", {Sel_SA, Sel_SB, Sel_SC, controleOperacao});
        else passed++;
    endtask

    task automatic test_alu_op();
        logic [15:0] w;
        w = 16'b00011_10_01_11_00000;
        run_one(w);
        checks++;
        if ({d_sa, d_sb, d_op} !== {2'b01, 2'b11, 5'b00011})
            $display("FAIL alu_decode: got %b expected %b", {d_sa, d_sb, d_op}, {2'b01, 2'b11, 5'b00011});
        else passed++;
        checks++;
        if ({d_ready, d_busy} !== 2'b01) $display("FAIL alu_decode_hs: got %b expected 01", {d_ready, d_busy});
        else passed++;
        checks++;
        if ({e_sa, e_sb, e_op, e_sc} !== {2'b01, 2'b11, 5'b00011, 2'b10})
            $display("FAIL alu_exec: got %b expected %b", {e_sa, e_sb, e_op, e_sc}, {2'b01, 2'b11, 5'b00011, 2'b10});
        else passed++;
        checks++;
        if ({w_sc, w_hab, w_rf} !== {2'b10, 1'b1, 1'b0})
            $display("FAIL alu_write: got %b expected 1010", {w_sc, w_hab, w_rf});
        else passed++;
        checks++;
        if ({d_hab, e_hab, i_hab} !== 3'b000) $display("FAIL alu_hab_width: got %b expected 000", {d_hab, e_hab, i_hab});
        else passed++;
        checks++;
        if ({i_ready, i_busy} !== 2'b10) $display("FAIL alu_ready_back: got %b expected 10", {i_ready, i_busy});
        else passed++;
    endtask

    task automatic test_nop_clrf();
        logic [15:0] w;
        w = {5'b11111, 11'($urandom)};
        run_one(w);
        checks++;
        if ({d_busy, e_busy, w_busy, i_busy} !== 4'b1110)
            $display("FAIL nop_busy: got %b expected 1110", {d_busy, e_busy, w_busy, i_busy});
        else passed++;
        checks++;
        if ({d_hab, e_hab, w_hab, i_hab, d_rf, e_rf, w_rf, i_rf} !== 8'h00)
            $display("FAIL nop_pulses: got %b expected 00000000", {d_hab, e_hab, w_hab, i_hab, d_rf, e_rf, w_rf, i_rf});
        else passed++;
        w = {5'b11110, 11'($urandom)};
        run_one(w);
        checks++;
        if ({d_rf, e_rf, w_rf, i_rf} !== 4'b0010)
            $display("FAIL clrf_rf: got %b expected 0010", {d_rf, e_rf, w_rf, i_rf});
        else passed++;
        checks++;
        if ({d_hab, e_hab, w_hab, i_hab} !== 4'b0000)
            $display("FAIL clrf_hab: got %b expected 0000", {d_hab, e_hab, w_hab, i_hab});
        else passed++;
    endtask

    task automatic test_random();
        logic [15:0] w;
        for (int n = 0; n < 12; n++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 3) == 0) w[15:11] = 5'($urandom_range(30, 31));
            run_one(w);
            checks++;
            if ({d_sa, d_sb, d_op} !== {m_ra(w), m_rb(w), m_op(w)})
                $display("FAIL rand_decode[%0d]: w=%h got %b expected %b", n, w, {d_sa, d_sb, d_op}, {m_ra(w), m_rb(w), m_op(w)});
            else passed++;
            checks++;
            if ({e_sa, e_sb, e_op, e_sc} !== {m_ra(w), m_rb(w), m_op(w), m_rd(w)})
                $display("FAIL rand_exec[%0d]: w=%h got %b expected %b", n, w, {e_sa, e_sb, e_op, e_sc}, {m_ra(w), m_rb(w), m_op(w), m_rd(w)});
            else passed++;
            checks++;
            if ({w_sc, w_hab, w_rf} !== {m_rd(w), m_write(w), m_clrf(w)})
                $display("FAIL rand_write[%0d]: w=%h got %b expected %b", n, w, {w_sc, w_hab, w_rf}, {m_rd(w), m_write(w), m_clrf(w)});
            else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w[3];
        int k;
        logic took;
        acc_q.delete(); acc_t.delete(); hab_sc.delete(); hab_t.delete();
        for (int i = 0; i < 3; i++) begin
            w[i] = 16'($urandom);
            w[i][15:11] = 5'($urandom_range(0, 29));
            w[i][10:9] = 2'(i + 1);
        end
        k = 0;
        instr = w[0];
        instr_valid = 1'b1;
        for (int c = 0; c < 20 && k < 3; c++) begin
            took = instr_ready;
            @(negedge clk);
            if (took) begin
                k++;
                if (k < 3) instr = w[k];
                else instr_valid = 1'b0;
            end
        end
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (acc_q.size() != 3) $display("FAIL b2b_accept_count: got %0d expected 3", acc_q.size());
        else passed++;
        checks++;
        if (hab_sc.size() != 3) $display("FAIL b2b_write_count: got %0d expected 3", hab_sc.size());
        else passed++;
        if (acc_q.size() == 3 && hab_sc.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (acc_q[i] !== w[i]) $display("FAIL b2b_word[%0d]: got %h expected %h", i, acc_q[i], w[i]);
                else passed++;
                checks++;
                if (hab_sc[i] !== m_rd(w[i])) $display("FAIL b2b_sc[%0d]: got %0d expected %0d", i, hab_sc[i], m_rd(w[i]));
                else passed++;
                checks++;
                if (hab_t[i] - acc_t[i] != 3) $display("FAIL b2b_latency[%0d]: got %0d expected 3", i, hab_t[i] - acc_t[i]);
                else passed++;
                if (i > 0) begin
                    checks++;
                    if (acc_t[i] - acc_t[i-1] != 4) $display("FAIL b2b_spacing[%0d]: got %0d expected 4", i, acc_t[i] - acc_t[i-1]);
                    else passed++;
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        hab_sc.delete(); hab_t.delete();
        rf_cnt = 0;
        instr = {5'd7, 11'($urandom)};
        instr_valid = 1'b1;
        @(negedge clk);
        instr_valid = 1'b0;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({instr_ready, busy, Hab_Escrita, reset_Flags, Sel_SA, Sel_SB, Sel_SC, controleOperacao} !== {4'b1000, 11'h0})
            $display("FAIL midrst_outputs: got %b expected %b",
                     {instr_ready, busy, Hab_Escrita, reset_Flags, Sel_SA, Sel_SB, Sel_SC, controleOperacao}, {4'b1000, 11'h0});
        else passed++;
        @(negedge clk);
        reset_n = 1'b1;
        repeat (5) @(negedge clk);
        checks++;
        if (hab_sc.size() != 0 || rf_cnt != 0)
            $display("FAIL midrst_no_write: got hab=%0d rf=%0d expected 0 0", hab_sc.size(), rf_cnt);
        else passed++;
    endtask

`ifdef INSTR_COUNT_EN
    task automatic test_instr_count();
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_count !== 16'd0) $display("FAIL count_reset: got %0d expected 0", instr_count);
        else passed++;
        run_one({5'd31, 11'h0});
        run_one({5'd30, 11'h0});
        for (int i = 0; i < 3; i++) run_one({5'($urandom_range(0, 29)), 11'($urandom)});
        checks++;
        if (instr_count !== 16'd5) $display("FAIL count_five: got %0d expected 5", instr_count);
        else passed++;
    endtask
`endif

    initial begin
        @(negedge clk);
        test_reset();
        test_alu_op();
        test_nop_clrf();
        test_random();
        test_back_to_back();
        test_mid_reset();
`ifdef INSTR_COUNT_EN
        test_instr_count();
`endif
        checks++;
        if (both_hi != 0) $display("FAIL hab_rf_overlap: got %0d expected 0", both_hi);
        else passed++;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
